// File: rtl/block_scheduler.sv
// -----------------------------------------------------------------------------
// block_scheduler
//
// Ping-pong scheduler that moves a job of N 8x8 blocks through a two-bank
// buffer. A load channel asks an external loader to fill a bank. A compute
// channel asks the DCT control FSM to transform a filled bank. Both channels
// run concurrently on opposite banks. Blocks are computed in the order in
// which they were loaded.
//
// Ports
//   clk_i          single clock, all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   start_i        job request, sampled only while idle
//   num_blocks_i   block count of the job, latched when start_i is accepted
//   load_start_o   one-cycle command to the loader to fill bank load_bank_o
//   load_bank_o    target bank of the current or last load
//   load_done_i    one-cycle pulse from the loader: the bank is filled
//   dct_start_o    one-cycle start pulse to the DCT control FSM
//   dct_bank_o     bank read by the DCT, held stable while it is busy
//   dct_done_i     one-cycle pulse from the DCT: the block is finished
//   block_count_o  blocks completed in the current or last job
//   busy_o         high while a job is running
//   done_o         one-cycle pulse after the last block completes
// -----------------------------------------------------------------------------
module block_scheduler #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] num_blocks_i,
   output logic             load_start_o,
   output logic             load_bank_o,
   input  logic             load_done_i,
   output logic             dct_start_o,
   output logic             dct_bank_o,
   input  logic             dct_done_i,
   output logic [CNT_W-1:0] block_count_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic {
      L_IDLE = 1'b0,
      L_BUSY = 1'b1
   } load_state_e;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_BUSY = 1'b1
   } comp_state_e;

   // Job control state
   state_e      state_q,   state_d;
   load_state_e l_state_q, l_state_d;
   comp_state_e c_state_q, c_state_d;

   // Bank bookkeeping: full flag per bank, load pointer and compute pointer
   logic [1:0]       full_q,  full_d;
   logic             lp_q,    lp_d;
   logic             cp_q,    cp_d;

   // Counters
   logic [CNT_W-1:0] n_q,     n_d;
   logic [CNT_W-1:0] loads_q, loads_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Registered outputs
   logic load_start_q, load_start_d;
   logic load_bank_q,  load_bank_d;
   logic dct_start_q,  dct_start_d;
   logic dct_bank_q,   dct_bank_d;
   logic busy_q,       busy_d;
   logic done_q,       done_d;

   // ---------------------------------------------------------------------------
   // Next-state logic
   //
   // Each edge first applies the completion events (load_done_i, dct_done_i)
   // and then makes the issue decisions on the resulting state. Because the
   // start pulses are registered, a pulse and the channel's move to BUSY land
   // on the same edge. This puts the pulse in the first cycle whose registered
   // Full/lp/cp allow it, e.g. Dct_Start in the cycle after the Load_Done that
   // filled the bank.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d      = state_q;
      l_state_d    = l_state_q;
      c_state_d    = c_state_q;
      full_d       = full_q;
      lp_d         = lp_q;
      cp_d         = cp_q;
      n_d          = n_q;
      loads_d      = loads_q;
      count_d      = count_q;
      load_bank_d  = load_bank_q;
      dct_bank_d   = dct_bank_q;
      load_start_d = 1'b0;
      dct_start_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A zero-block request is ignored outright: no job and no Done.
            if (start_i && (num_blocks_i != '0)) begin
               state_d    = S_RUN;
               n_d        = num_blocks_i;
               loads_d    = '0;
               count_d    = '0;
               full_d     = 2'b00;
               lp_d       = 1'b0;
               cp_d       = 1'b0;
               l_state_d  = L_IDLE;
               c_state_d  = C_IDLE;
               dct_bank_d = 1'b0;
            end
         end

         S_RUN: begin
            // Done pulses arriving while a channel is idle are ignored.
            if ((l_state_q == L_BUSY) && load_done_i) begin
               full_d[lp_q] = 1'b1;
               lp_d         = ~lp_q;
               l_state_d    = L_IDLE;
            end
            // The two channels always address different banks, so both
            // events can be applied in the same cycle without conflict.
            if ((c_state_q == C_BUSY) && dct_done_i) begin
               full_d[cp_q] = 1'b0;
               cp_d         = ~cp_q;
               count_d      = count_q + 1'b1;
               c_state_d    = C_IDLE;
               if (count_d == n_q) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Issue decisions, shared by the accept edge and normal running.
      if (state_d == S_RUN) begin
         if ((l_state_d == L_IDLE) && (loads_d < n_d) && !full_d[lp_d]) begin
            load_start_d = 1'b1;
            load_bank_d  = lp_d;
            loads_d      = loads_d + 1'b1;
            l_state_d    = L_BUSY;
         end
         if ((c_state_d == C_IDLE) && full_d[cp_d]) begin
            dct_start_d = 1'b1;
            dct_bank_d  = cp_d;
            c_state_d   = C_BUSY;
         end
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the values from before this edge, independent of statement order.
      // Reset is synchronous and overrides every other input.
      if (rst_i) begin
         state_q      <= S_IDLE;
         l_state_q    <= L_IDLE;
         c_state_q    <= C_IDLE;
         full_q       <= 2'b00;
         lp_q         <= 1'b0;
         cp_q         <= 1'b0;
         n_q          <= '0;
         loads_q      <= '0;
         count_q      <= '0;
         load_start_q <= 1'b0;
         load_bank_q  <= 1'b0;
         dct_start_q  <= 1'b0;
         dct_bank_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         l_state_q    <= l_state_d;
         c_state_q    <= c_state_d;
         full_q       <= full_d;
         lp_q         <= lp_d;
         cp_q         <= cp_d;
         n_q          <= n_d;
         loads_q      <= loads_d;
         count_q      <= count_d;
         load_start_q <= load_start_d;
         load_bank_q  <= load_bank_d;
         dct_start_q  <= dct_start_d;
         dct_bank_q   <= dct_bank_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign load_start_o  = load_start_q;
   assign load_bank_o   = load_bank_q;
   assign dct_start_o   = dct_start_q;
   assign dct_bank_o    = dct_bank_q;
   assign block_count_o = count_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_block_scheduler
//
// Self-checking bench for block_scheduler. It runs three parts. A vector table
// covers reset, the single-block job and the ignored inputs. Hand-written
// sequences cover overlap, simultaneous completions and a mid-job reset.
// Random loader/DCT traffic is then checked cycle by cycle against a
// job-level reference model.
// -----------------------------------------------------------------------------
module tb_block_scheduler;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] nb;
   logic             ld;
   logic             dd;
   logic             load_start;
   logic             load_bank;
   logic             dct_start;
   logic             dct_bank;
   logic [CNT_W-1:0] block_count;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   block_scheduler #(.CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .num_blocks_i  (nb),
      .load_start_o  (load_start),
      .load_bank_o   (load_bank),
      .load_done_i   (ld),
      .dct_start_o   (dct_start),
      .dct_bank_o    (dct_bank),
      .dct_done_i    (dd),
      .block_count_o (block_count),
      .busy_o        (busy),
      .done_o        (done)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------------------------------------------------------------------
   // Reference model. It tracks the job as counts: blocks issued, landed and
   // completed. The bank used by block k is k mod 2.
   // ---------------------------------------------------------------------------
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   int m_mode = M_IDLE;
   int m_n, m_issued, m_landed, m_completed;
   bit m_filled [2];
   bit m_ld_busy, m_dc_busy;
   bit m_ls, m_lb, m_ds, m_db;

   task automatic model_step();
      m_ls = 1'b0;
      m_ds = 1'b0;
      if (rst) begin
         m_mode = M_IDLE; m_n = 0; m_issued = 0; m_landed = 0; m_completed = 0;
         m_filled = '{1'b0, 1'b0}; m_ld_busy = 1'b0; m_dc_busy = 1'b0;
         m_lb = 1'b0; m_db = 1'b0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (start && nb != 0) begin
                  m_mode = M_RUN; m_n = int'(nb);
                  m_issued = 0; m_landed = 0; m_completed = 0;
                  m_filled = '{1'b0, 1'b0}; m_ld_busy = 1'b0; m_dc_busy = 1'b0;
                  m_db = 1'b0;
               end
            end
            M_RUN: begin
               if (m_ld_busy && ld) begin
                  m_filled[m_landed % 2] = 1'b1;
                  m_landed++;
                  m_ld_busy = 1'b0;
               end
               if (m_dc_busy && dd) begin
                  m_filled[m_completed % 2] = 1'b0;
                  m_completed++;
                  m_dc_busy = 1'b0;
                  if (m_completed == m_n) m_mode = M_DONE;
               end
            end
            default: m_mode = M_IDLE;
         endcase
         if (m_mode == M_RUN) begin
            if (!m_ld_busy && m_issued < m_n && !m_filled[m_issued % 2]) begin
               m_ls = 1'b1;
               m_lb = (m_issued % 2) != 0;
               m_issued++;
               m_ld_busy = 1'b1;
            end
            if (!m_dc_busy && m_filled[m_completed % 2]) begin
               m_ds = 1'b1;
               m_db = (m_completed % 2) != 0;
               m_dc_busy = 1'b1;
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] pk(input logic ls, lb, ds, db,
                                      input logic [7:0] cnt,
                                      input logic bsy, dn);
      return {18'd0, ls, lb, ds, db, cnt, bsy, dn};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {ls,lb,ds,db,cnt,busy,done}=%h, want %h",
                  name, act, exp);
      end
   endtask

   // Inputs are driven on the falling edge. The rising edge is followed by the
   // model update, and outputs are sampled on the next falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic cyc(input int r, s, n, l, d);
      rst = 1'(r); start = 1'(s); nb = 8'(n); ld = 1'(l); dd = 1'(d);
      tick();
   endtask

   task automatic expect_o(input string name, input int ls, lb, ds, db, cnt,
                           e_busy, e_done);
      check(name,
            pk(load_start, load_bank, dct_start, dct_bank, block_count, busy, done),
            pk(1'(ls), 1'(lb), 1'(ds), 1'(db), 8'(cnt), 1'(e_busy), 1'(e_done)));
   endtask

   // ---------------------------------------------------------------------------
   // Vector table: inputs for one cycle (repeated reps times) and the outputs
   // expected in the following cycle.
   // ---------------------------------------------------------------------------
   typedef struct {
      int rst, st, nb, ld, dd, reps;
      int ls, lb, ds, db, cnt, busy, done;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   int ld_wait, dc_wait;
   bit ld_pend, dc_pend, big_job;

   initial begin
      rst = 1'b1; start = 1'b0; nb = '0; ld = 1'b0; dd = 1'b0;

      //        rst st nb ld dd reps   ls lb ds db cnt busy done
      vecs = '{ '{1, 0, 0, 0, 0, 2,    0, 0, 0, 0, 0, 0, 0},  // reset
                '{0, 0, 0, 0, 0, 3,    0, 0, 0, 0, 0, 0, 0},  // quiet
                '{0, 1, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0},  // Start, N=0
                '{0, 0, 0, 1, 1, 1,    0, 0, 0, 0, 0, 0, 0},  // stray dones, idle
                '{0, 0, 0, 0, 0, 2,    0, 0, 0, 0, 0, 0, 0},
                '{0, 1, 1, 0, 0, 1,    1, 0, 0, 0, 0, 1, 0},  // c0 Start N=1
                '{0, 0, 0, 0, 1, 3,    0, 0, 0, 0, 0, 1, 0},  // c1-3 stray Dct_Done
                '{0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 1, 0},  // c4
                '{0, 0, 0, 1, 0, 1,    0, 0, 1, 0, 0, 1, 0},  // c5 Load_Done
                '{0, 0, 0, 1, 0, 2,    0, 0, 0, 0, 0, 1, 0},  // c6-7 stray Load_Done
                '{0, 1, 5, 0, 0, 1,    0, 0, 0, 0, 0, 1, 0},  // c8 Start in RUN
                '{0, 0, 0, 0, 0, 11,   0, 0, 0, 0, 0, 1, 0},  // c9-19
                '{0, 0, 0, 0, 1, 1,    0, 0, 0, 0, 1, 0, 1},  // c20 Dct_Done
                '{0, 0, 0, 0, 0, 3,    0, 0, 0, 0, 1, 0, 0} };// hold after DONE

      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            cyc(vecs[i].rst, vecs[i].st, vecs[i].nb, vecs[i].ld, vecs[i].dd);
            expect_o($sformatf("vec%0d.%0d", i, r), vecs[i].ls, vecs[i].lb,
                     vecs[i].ds, vecs[i].db, vecs[i].cnt, vecs[i].busy,
                     vecs[i].done);
         end
      end

      // N=3 with overlap of load and compute.
      cyc(0, 1, 3, 0, 0); expect_o("n3 load0",        1, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n3 wait",         0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("n3 dct0+load1",   1, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n3 quiet",        0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("n3 both full",    0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n3 hold",         0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("n3 load0+dct1",   1, 0, 1, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n3 quiet2",       0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("n3 load2 landed", 0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("n3 dct2",         0, 0, 1, 0, 2, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n3 quiet3",       0, 0, 0, 0, 2, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("n3 done",         0, 0, 0, 0, 3, 0, 1);
      cyc(0, 0, 0, 0, 0); expect_o("n3 idle",         0, 0, 0, 0, 3, 0, 0);

      // N=4 with Load_Done and Dct_Done in the same cycle.
      cyc(0, 1, 4, 0, 0); expect_o("sim load0",       1, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("sim dct0+load1",  1, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("sim quiet",       0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1); expect_o("sim both a",      1, 0, 1, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("sim quiet b",     0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1); expect_o("sim both b",      1, 1, 1, 0, 2, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("sim quiet c",     0, 1, 0, 0, 2, 1, 0);
      cyc(0, 0, 0, 1, 1); expect_o("sim both c",      0, 1, 1, 1, 3, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("sim quiet d",     0, 1, 0, 1, 3, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("sim done",        0, 1, 0, 1, 4, 0, 1);
      cyc(0, 0, 0, 0, 0); expect_o("sim hold",        0, 1, 0, 1, 4, 0, 0);

      // Reset mid-job with compute busy and both banks full, then N=2.
      cyc(0, 1, 3, 0, 0); expect_o("mr load0",        1, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("mr dct0+load1",   1, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("mr quiet",        0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("mr both full",    0, 1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0); expect_o("mr reset",        0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0); expect_o("mr after reset",  0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 2, 0, 0); expect_o("n2 load0",        1, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("n2 dct0+load1",   1, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n2 quiet",        0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0); expect_o("n2 load1 landed", 0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("n2 dct1",         0, 1, 1, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0); expect_o("n2 quiet2",       0, 1, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 1); expect_o("n2 done",         0, 1, 0, 1, 2, 0, 1);
      cyc(0, 0, 0, 0, 0); expect_o("n2 hold",         0, 1, 0, 1, 2, 0, 0);

      // Random loader/DCT latencies, stray pulses, random starts and rare
      // resets. The first job uses the largest block count.
      ld_pend = 1'b0; dc_pend = 1'b0; big_job = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         rst = 1'b0; start = 1'b0; nb = '0; ld = 1'b0; dd = 1'b0;
         if (c > 2000 && $urandom_range(0, 599) == 0) begin
            rst = 1'b1; ld_pend = 1'b0; dc_pend = 1'b0;
         end else begin
            if (big_job && m_mode == M_IDLE) begin
               start = 1'b1; nb = 8'd255; big_job = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               start = 1'b1; nb = 8'($urandom_range(0, 5));
            end
            if (m_ls) begin
               ld_wait = $urandom_range(0, 4); ld_pend = 1'b1;
            end else if (ld_pend) begin
               if (ld_wait == 0) begin ld = 1'b1; ld_pend = 1'b0; end
               else ld_wait--;
            end else if ($urandom_range(0, 9) == 0) begin
               ld = 1'b1;
            end
            if (m_ds) begin
               dc_wait = $urandom_range(0, 4); dc_pend = 1'b1;
            end else if (dc_pend) begin
               if (dc_wait == 0) begin dd = 1'b1; dc_pend = 1'b0; end
               else dc_wait--;
            end else if ($urandom_range(0, 9) == 0) begin
               dd = 1'b1;
            end
         end
         tick();
         check($sformatf("rand cycle %0d", c),
               pk(load_start, load_bank, dct_start, dct_bank, block_count, busy, done),
               pk(m_ls, m_lb, m_ds, m_db, 8'(m_completed),
                  m_mode == M_RUN, m_mode == M_DONE));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 Parameter CNT_W, default 8, width of the block count and counters.
REQ-002 Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  reset, synchronous and active-high.
REQ-004 Start  in  1  request to transform Num_Blocks 8x8 blocks; sampled only in IDLE.
REQ-005 Num_Blocks  in  CNT_W  number of blocks in the job; latched on the accepted Start.
REQ-006 Load_Start  out  1  one-cycle pulse commanding the loader to fill bank Load_Bank with the next block.
REQ-007 Load_Bank  out  1  target bank of the current or last load.
REQ-008 Load_Done  in  1  one-cycle pulse from the loader: the bank is filled.
REQ-009 Dct_Start  out  1  one-cycle pulse to the DCT control FSM Start input.
REQ-010 Dct_Bank  out  1  bank the DCT control FSM reads, held stable while the compute is busy.
REQ-011 Dct_Done  in  1  one-cycle pulse derived from the DCT control FSM Ready: block finished.
REQ-012 Block_Count  out  CNT_W  number of blocks completed in the current or last job.
REQ-013 Busy  out  1  high while a job is running.
REQ-014 Done  out  1  one-cycle pulse when the last block completes.

Function
REQ-015 The top FSM SHALL have states IDLE, RUN and DONE.
  - IDLE to RUN: Start=1 and Num_Blocks!=0.
  - RUN to DONE: completed count reaches N.
  - DONE to IDLE: unconditional, after 1 cycle.
REQ-016 On IDLE to RUN:
  - latch N = Num_Blocks;
  - clear the loads-issued counter, Block_Count and Full[1:0];
  - set load pointer lp=0 and compute pointer cp=0.
REQ-017 The load channel SHALL be a 2-state FSM, L_IDLE and L_BUSY.
  - In RUN, with L_IDLE, loads_issued<N and Full[lp]=0: assert Load_Start for 1 cycle, drive Load_Bank=lp, increment loads_issued, enter L_BUSY.
REQ-018 On Load_Done in L_BUSY: Full[lp] is set, lp toggles, and the channel returns to L_IDLE.
REQ-019 The compute channel SHALL be a 2-state FSM, C_IDLE and C_BUSY.
  - In RUN, with C_IDLE and Full[cp]=1: assert Dct_Start for 1 cycle, drive Dct_Bank=cp, enter C_BUSY.
REQ-020 On Dct_Done in C_BUSY: Full[cp] is cleared, cp toggles, Block_Count increments, and the channel returns to C_IDLE.
REQ-021 Issue decisions SHALL use registered Full, lp and cp, giving these latencies:
  - Load_Start in the first cycle after Start is accepted;
  - Dct_Start no earlier than the cycle after the Load_Done that filled that bank;
  - a refill Load_Start no earlier than the cycle after the Dct_Done that freed that bank.
REQ-022 The load and compute channels SHALL run concurrently (ping-pong).
  - Load_Start and Dct_Start may be asserted in the same cycle, on opposite banks.
REQ-023 Load_Done and Dct_Done in the same cycle SHALL both be applied; they address different banks by construction.
REQ-024 Blocks SHALL be computed in load order; Dct_Bank alternates 0,1,0,...
REQ-025 Done SHALL pulse in the cycle after the Dct_Done that makes Block_Count=N, with Busy low in that same cycle.
REQ-026 Busy SHALL be high exactly while in RUN.
REQ-027 The following inputs SHALL be ignored:
  - Start while not in IDLE;
  - Start with Num_Blocks=0 (no Done);
  - Load_Done in L_IDLE;
  - Dct_Done in C_IDLE.
REQ-028 Block_Count, Load_Bank and Dct_Bank SHALL hold their values after DONE until the next accepted Start.
REQ-029 Counters SHALL be CNT_W bits with no wrap; the maximum job is 2^CNT_W-1 blocks.

Reset
REQ-030 Reset=1 at a clock edge SHALL force the following, overriding every other input, including mid-job:
  - state IDLE, L_IDLE and C_IDLE;
  - Full=00, lp=cp=0;
  - all counters 0;
  - Load_Start, Load_Bank, Dct_Start, Dct_Bank, Block_Count, Busy and Done all 0.
REQ-031 No pulse output SHALL be asserted in the cycle after a reset.

Verification
REQ-032 Reset asserted for 2 cycles -> all outputs 0; Start held low afterwards -> outputs stay 0.
REQ-033 N=1; Start at cycle 0; Load_Done at cycle 5 -> expected responses:
  - Load_Start, Load_Bank=0 at cycle 1;
  - Dct_Start, Dct_Bank=0 at cycle 6;
  - Dct_Done at cycle 20 -> Done at cycle 21, Block_Count=1, Busy=0.
REQ-034 N=3, overlap -> expected responses:
  - after the first Load_Done: Dct_Start(bank 0) and Load_Start(bank 1) in the same cycle;
  - the third Load_Start (bank 0) waits until the cycle after block 0's Dct_Done, which is also the cycle of Dct_Start for bank 1;
  - Done after the 3rd Dct_Done, Block_Count=3.
REQ-035 Load_Done and Dct_Done driven in the same cycle -> both take effect: Full flips on both banks, Block_Count+1, and the next load and compute issue in the following cycle.
REQ-036 Ignored inputs -> expected responses:
  - Start with Num_Blocks=0: Busy stays 0 and no pulses;
  - Start during RUN: no relatch of N;
  - spurious Load_Done or Dct_Done while the channel is idle: no effect.
REQ-037 Reset asserted mid-job (during C_BUSY with both banks full) -> next cycle all outputs 0; a fresh Start with N=2 then completes normally with Block_Count=2.
